// File: rtl/sprite_rom_pkg.sv
// ----------------------------------------------------------------------------
// sprite_rom_pkg
//   Shared constants and types for the sprite ROM arbiter.
//   - ADDR_W / DATA_W : default ROM address and palette-index widths
//   - IDLE_ADDR       : address presented when no read is issued
//   - BLANK_PAL       : palette index (black) returned to the pixel path
//   - rd_kind_t       : kind of read occupying a tag pipeline stage
//   - rd_tag_t        : {kind, requester id} carried alongside a ROM read
// ----------------------------------------------------------------------------
package sprite_rom_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 5;

    localparam logic [ADDR_W-1:0] IDLE_ADDR = 18'd1706;
    localparam logic [DATA_W-1:0] BLANK_PAL = 5'd18;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        PIX  = 2'd1,
        AUX  = 2'd2
    } rd_kind_t;

    typedef struct packed {
        rd_kind_t   kind;
        logic [1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// ----------------------------------------------------------------------------
// sprite_rom_arbiter_if
//   Bus bundle between the colour mapper / auxiliary readers / ROM and the
//   arbiter.
//   - blank, pix_addr, pix_q           : pixel path (blank=1 means active video)
//   - aux_req, aux_addr                : per-requester level request + address
//   - aux_gnt, aux_valid, aux_q        : grant, return strobe, shared return data
//   - rom_addr, rom_q                  : ROM address / data ports
//   master: the surrounding system (requesters + ROM); slave: the arbiter.
// ----------------------------------------------------------------------------
interface sprite_rom_arbiter_if #(
    parameter int N_AUX  = 2,
    parameter int ADDR_W = sprite_rom_pkg::ADDR_W,
    parameter int DATA_W = sprite_rom_pkg::DATA_W
);

    logic                          blank;
    logic [ADDR_W-1:0]             pix_addr;
    logic [DATA_W-1:0]             pix_q;
    logic [N_AUX-1:0]              aux_req;
    logic [N_AUX-1:0][ADDR_W-1:0]  aux_addr;
    logic [N_AUX-1:0]              aux_gnt;
    logic [N_AUX-1:0]              aux_valid;
    logic [DATA_W-1:0]             aux_q;
    logic [ADDR_W-1:0]             rom_addr;
    logic [DATA_W-1:0]             rom_q;

    modport master (
        output blank, pix_addr, aux_req, aux_addr, rom_q,
        input  pix_q, aux_gnt, aux_valid, aux_q, rom_addr
    );

    modport slave (
        input  blank, pix_addr, aux_req, aux_addr, rom_q,
        output pix_q, aux_gnt, aux_valid, aux_q, rom_addr
    );

endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   N-way round-robin arbiter with a combinational one-hot grant.
//   - clk, rst_n : clock, asynchronous active-low reset
//   - i_en       : grants are only produced while high
//   - i_req      : request vector
//   - o_gnt      : one-hot grant (all zero when disabled or no request)
//   The last-granted pointer resets to N-1 so requester 0 wins first, and
//   only moves when a grant is actually given.
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_last_gnt;
    logic [PTR_W-1:0] w_winner;
    logic             w_found;

    // Scan priorities in order last+1, last+2, ... (mod N); first hit wins.
    always_comb begin
        o_gnt    = '0;
        w_found  = 1'b0;
        w_winner = r_last_gnt;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (i_en && !w_found && i_req[i] &&
                    (i == ((32'(r_last_gnt) + 32'd1 + k) % N))) begin
                    o_gnt[i] = 1'b1;
                    w_found  = 1'b1;
                    w_winner = PTR_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= PTR_W'(N - 1);
        end else if (w_found) begin
            r_last_gnt <= w_winner;
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// ----------------------------------------------------------------------------
// sprite_rom_arbiter
//   Shares the single-port sprite ROM between the pixel path and up to four
//   auxiliary readers (collision checker, HUD renderer, ...).
//   - clk, Reset_n : clock, asynchronous active-low reset
//   - bus (slave)  : pixel path, auxiliary request/grant/return, ROM ports
//   During active video (blank=1) the pixel address goes straight to the ROM.
//   During blanking one auxiliary requester per cycle is granted round-robin.
//   A ROM_LAT-deep tag pipeline tracks what each in-flight read was so its
//   data can be steered back to the pixel path or to the right requester.
// ----------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int                N_AUX     = 2,
    parameter int                ADDR_W    = sprite_rom_pkg::ADDR_W,
    parameter int                DATA_W    = sprite_rom_pkg::DATA_W,
    parameter int                ROM_LAT   = 1,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = sprite_rom_pkg::IDLE_ADDR,
    parameter logic [DATA_W-1:0] BLANK_PAL = sprite_rom_pkg::BLANK_PAL
) (
    input  logic                 clk,
    input  logic                 Reset_n,
    sprite_rom_arbiter_if.slave  bus
);

    import sprite_rom_pkg::*;

    logic              w_en;
    logic [N_AUX-1:0]  w_gnt;
    logic [ADDR_W-1:0] w_aux_addr;
    rd_tag_t           w_issue;
    rd_tag_t           w_out;
    logic [N_AUX-1:0]  w_aux_valid;

    rd_tag_t           r_tag [ROM_LAT];

    assign w_en = ~bus.blank;

    rr_arbiter #(
        .N (N_AUX)
    ) u_arb (
        .clk   (clk),
        .rst_n (Reset_n),
        .i_en  (w_en),
        .i_req (bus.aux_req),
        .o_gnt (w_gnt)
    );

    // Issue side: select the winning auxiliary address and tag this read.
    always_comb begin
        w_aux_addr   = '0;
        w_issue.kind = NONE;
        w_issue.id   = '0;
        for (int unsigned i = 0; i < N_AUX; i++) begin
            if (w_gnt[i]) begin
                w_aux_addr = w_aux_addr | bus.aux_addr[i];
                w_issue.id = 2'(i);
            end
        end
        if (bus.blank) begin
            w_issue.kind = PIX;
            w_issue.id   = '0;
        end else if (|w_gnt) begin
            w_issue.kind = AUX;
        end
    end

    assign bus.rom_addr = bus.blank ? bus.pix_addr :
                          (|w_gnt)  ? w_aux_addr   : IDLE_ADDR;
    assign bus.aux_gnt  = w_gnt;

    // Tag shift register, aligned with the ROM's internal read latency.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                r_tag[i] <= '{kind: NONE, id: 2'd0};
            end
        end else begin
            r_tag[0] <= w_issue;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Return side: the output-stage tag says who owns rom_q this cycle.
    assign w_out = r_tag[ROM_LAT-1];

    always_comb begin
        w_aux_valid = '0;
        for (int unsigned i = 0; i < N_AUX; i++) begin
            w_aux_valid[i] = (w_out.kind == AUX) && (w_out.id == 2'(i));
        end
    end

    assign bus.aux_valid = w_aux_valid;
    assign bus.aux_q     = bus.rom_q;
    assign bus.pix_q     = (w_out.kind == PIX) ? bus.rom_q : BLANK_PAL;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//   Two arbiters (ROM_LAT=1 and ROM_LAT=2) share one stimulus stream, each
//   with its own ROM model. A cycle-history model predicts grants, ROM address
//   and returns every cycle; directed literal checks pin the model.
// ----------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

    localparam int              NA  = 2;
    localparam int              AW  = 18;
    localparam int              DW  = 5;
    localparam logic [DW-1:0]   BP  = 5'd18;
    localparam logic [AW-1:0]   IA  = 18'd1706;
    localparam int              HMAX = 512;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   blank = 1'b1;
    logic [AW-1:0]          pix_addr = '0;
    logic [NA-1:0]          aux_req = '0;
    logic [NA-1:0][AW-1:0]  aux_addr = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(.N_AUX(NA), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
    sprite_rom_arbiter_if #(.N_AUX(NA), .ADDR_W(AW), .DATA_W(DW)) bus2 ();

    sprite_rom_arbiter #(
        .N_AUX(NA), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1),
        .IDLE_ADDR(IA), .BLANK_PAL(BP)
    ) dut1 (
        .clk(clk), .Reset_n(rst_n), .bus(bus1)
    );

    sprite_rom_arbiter #(
        .N_AUX(NA), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2),
        .IDLE_ADDR(IA), .BLANK_PAL(BP)
    ) dut2 (
        .clk(clk), .Reset_n(rst_n), .bus(bus2)
    );

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a ^ (a >> 5) ^ (a >> 10);
        return t[DW-1:0];
    endfunction

    // ROM models: registered address, read latency 1 and 2.
    logic [AW-1:0] a1_p0 = '0;
    logic [AW-1:0] a2_p0 = '0;
    logic [AW-1:0] a2_p1 = '0;

    always @(posedge clk) begin
        a1_p0 <= bus1.rom_addr;
        a2_p0 <= bus2.rom_addr;
        a2_p1 <= a2_p0;
    end

    assign bus1.blank = blank;    assign bus2.blank = blank;
    assign bus1.pix_addr = pix_addr; assign bus2.pix_addr = pix_addr;
    assign bus1.aux_req = aux_req;  assign bus2.aux_req = aux_req;
    assign bus1.aux_addr = aux_addr; assign bus2.aux_addr = aux_addr;
    assign bus1.rom_q = rom_f(a1_p0);
    assign bus2.rom_q = rom_f(a2_p1);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // History of what was issued in each cycle; a read issued in cycle s
    // appears at the outputs in cycle s+LAT unless a reset intervened.
    int            cyc = 0;
    int            m_last = NA - 1;
    int            first_valid = 0;
    int            h_kind [HMAX];   // 0 none, 1 pixel, 2 aux
    int            h_id   [HMAX];
    logic [AW-1:0] h_addr [HMAX];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_ret(input string nm, input int lat, input logic [NA-1:0] valid,
                             input logic [DW-1:0] pq, input logic [DW-1:0] aq);
        int src;
        int k;
        logic [NA-1:0] e_valid;
        logic [DW-1:0] e_pix;
        src = cyc - lat;
        k = 0;
        if (src >= 0 && src >= first_valid) k = h_kind[src];
        e_valid = '0;
        e_pix   = BP;
        if (k == 1) e_pix = rom_f(h_addr[src]);
        if (k == 2) e_valid[h_id[src]] = 1'b1;
        chk({nm, "_aux_valid"}, 32'(valid), 32'(e_valid));
        chk({nm, "_pix_q"}, 32'(pq), 32'(e_pix));
        if (k == 2) chk({nm, "_aux_q"}, 32'(aq), 32'(rom_f(h_addr[src])));
    endtask

    always @(negedge clk) begin
        logic [NA-1:0] e_gnt;
        logic [AW-1:0] e_addr;
        int            win;
        if (cyc >= HMAX) begin
            $display("FAIL model_history: cycle %0d exceeds %0d", cyc, HMAX);
            $fatal(1);
        end
        if (!rst_n) begin
            m_last      = NA - 1;
            first_valid = cyc + 1;
        end
        e_gnt  = '0;
        win    = -1;
        e_addr = IA;
        h_kind[cyc] = 0;
        h_id[cyc]   = 0;
        if (blank) begin
            e_addr = pix_addr;
            h_kind[cyc] = 1;
        end else begin
            for (int k = 0; k < NA; k++) begin
                int i;
                i = (m_last + 1 + k) % NA;
                if (win < 0 && aux_req[i]) win = i;
            end
            if (win >= 0) begin
                e_gnt[win] = 1'b1;
                e_addr = aux_addr[win];
                h_kind[cyc] = 2;
                h_id[cyc]   = win;
            end
        end
        h_addr[cyc] = e_addr;
        chk("m_gnt1", 32'(bus1.aux_gnt), 32'(e_gnt));
        chk("m_gnt2", 32'(bus2.aux_gnt), 32'(e_gnt));
        chk("m_rom_addr1", 32'(bus1.rom_addr), 32'(e_addr));
        chk("m_rom_addr2", 32'(bus2.rom_addr), 32'(e_addr));
        if (rst_n && win >= 0) m_last = win;
        check_ret("m_lat1", 1, bus1.aux_valid, bus1.pix_q, bus1.aux_q);
        check_ret("m_lat2", 2, bus2.aux_valid, bus2.pix_q, bus2.aux_q);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: tags cleared, grant still combinational
        blank = 1'b0;
        aux_req = 2'b11;
        repeat (3) tick();
        #3;
        chk("reset_pix_q1", 32'(bus1.pix_q), 32'd18);
        chk("reset_pix_q2", 32'(bus2.pix_q), 32'd18);
        chk("reset_valid1", 32'(bus1.aux_valid), 32'd0);
        chk("reset_gnt", 32'(bus1.aux_gnt), 32'b01);
        tick();
        blank = 1'b1;
        aux_req = 2'b00;
        tick();
        rst_n = 1'b1;

        // Pixel passthrough
        blank = 1'b1; aux_req = 2'b11;
        aux_addr[0] = 18'd5; aux_addr[1] = 18'd6;
        pix_addr = 18'd100;
        #3;
        chk("pix_rom_addr", 32'(bus1.rom_addr), 32'd100);
        chk("pix_gnt", 32'(bus1.aux_gnt), 32'd0);
        tick(); pix_addr = 18'd101; #3;
        chk("pix_q_100", 32'(bus1.pix_q), 32'd7);
        chk("pix_rom_addr2", 32'(bus1.rom_addr), 32'd101);
        tick(); pix_addr = 18'd102; #3;
        chk("pix_q_101", 32'(bus1.pix_q), 32'd6);
        tick(); #3;
        chk("pix_q_102", 32'(bus1.pix_q), 32'd5);

        // Fairness from reset pointer
        tick();
        blank = 1'b0; aux_addr[0] = 18'd300; aux_addr[1] = 18'd400; aux_req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #3;
            chk("fair_gnt", 32'(bus1.aux_gnt), (i % 2 == 0) ? 32'b01 : 32'b10);
            tick();
        end

        // Single auxiliary read, then idle
        aux_req = 2'b01; aux_addr[0] = 18'd1705; #3;
        chk("single_gnt", 32'(bus1.aux_gnt), 32'b01);
        chk("single_rom_addr", 32'(bus1.rom_addr), 32'd1705);
        tick(); aux_req = 2'b00; #3;
        chk("single_valid1", 32'(bus1.aux_valid), 32'b01);
        chk("single_q1", 32'(bus1.aux_q), 32'd29);
        chk("single_pix_q", 32'(bus1.pix_q), 32'd18);
        chk("idle_addr_a", 32'(bus1.rom_addr), 32'd1706);
        tick(); #3;
        chk("single_valid2", 32'(bus2.aux_valid), 32'b01);
        chk("single_q2", 32'(bus2.aux_q), 32'd29);
        chk("idle_valid1", 32'(bus1.aux_valid), 32'd0);
        tick(); #3;
        chk("idle_addr_b", 32'(bus1.rom_addr), 32'd1706);
        chk("idle_valid2", 32'(bus2.aux_valid), 32'd0);

        // Blank boundary: aux 1 granted in the last blanking cycle
        tick(); aux_req = 2'b10; aux_addr[1] = 18'd777; #3;
        chk("bnd_gnt", 32'(bus1.aux_gnt), 32'b10);
        tick(); blank = 1'b1; pix_addr = 18'd200; aux_req = 2'b00; #3;
        chk("bnd_valid1", 32'(bus1.aux_valid), 32'b10);
        chk("bnd_q1", 32'(bus1.aux_q), 32'd17);
        chk("bnd_gnt_active", 32'(bus1.aux_gnt), 32'd0);
        chk("bnd_rom_addr", 32'(bus1.rom_addr), 32'd200);
        tick(); pix_addr = 18'd201; #3;
        chk("bnd_pix_q1", 32'(bus1.pix_q), 32'd14);
        chk("bnd_valid1_off", 32'(bus1.aux_valid), 32'd0);
        chk("bnd_valid2", 32'(bus2.aux_valid), 32'b10);
        chk("bnd_q2", 32'(bus2.aux_q), 32'd17);
        tick(); #3;
        chk("bnd_pix_q2", 32'(bus2.pix_q), 32'd14);
        chk("bnd_valid2_off", 32'(bus2.aux_valid), 32'd0);

        // Reset right after an aux grant: read dropped, pointer restored
        tick(); blank = 1'b0; aux_req = 2'b01; aux_addr[0] = 18'd900; #3;
        chk("rst_gnt_before", 32'(bus1.aux_gnt), 32'b01);
        tick(); rst_n = 1'b0; aux_req = 2'b00; #3;
        chk("rst_valid1", 32'(bus1.aux_valid), 32'd0);
        chk("rst_valid2_a", 32'(bus2.aux_valid), 32'd0);
        tick(); rst_n = 1'b1; #3;
        chk("rst_valid2_b", 32'(bus2.aux_valid), 32'd0);
        tick(); aux_req = 2'b11; #3;
        chk("rst_gnt_after", 32'(bus1.aux_gnt), 32'b01);
        chk("rst_valid2_c", 32'(bus2.aux_valid), 32'd0);
        tick(); aux_req = 2'b00; blank = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

- Shares the single-port sprite ROM (`spriteROM`, registered address, 5-bit palette index out) between the pixel path and auxiliary readers.
- Auxiliary readers are, for example, the collision checker and the HUD renderer; they need sprite/terrain masks.
- The pixel path owns the ROM during active video, at zero added latency.
- Auxiliary requesters are granted round-robin only during blanking, and their read data is routed back through a tag pipeline.
- The block sits between the colour mapper's address priority mux and the ROM instance.

## Interface
Parameters:
- N_AUX, 2, number of auxiliary requesters (1..4)
- ADDR_W, 18, ROM address width
- DATA_W, 5, palette index width
- ROM_LAT, 1, ROM read latency in clocks (1..3)
- IDLE_ADDR, 18'd1706, address driven when nobody reads
- BLANK_PAL, 5'd18, palette index returned to pixel path during blanking (black)

Ports:
- clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- blank  in  1  1 = active video (pixel owns ROM), 0 = blanking
- pix_addr  in  ADDR_W  pixel read address from colour-mapper priority mux
- pix_q  out  DATA_W  palette index for the pixel issued ROM_LAT cycles earlier
- aux_req  in  N_AUX  per-requester read request, level
- aux_addr  in  N_AUX×ADDR_W  per-requester address, stable while aux_req is high
- aux_gnt  out  N_AUX  one-hot grant, combinational, the cycle the address is issued
- aux_valid  out  N_AUX  one-hot, 1-cycle pulse when aux_q holds that requester's data
- aux_q  out  DATA_W  shared auxiliary read data
- rom_addr  out  ADDR_W  to ROM address port
- rom_q  in  DATA_W  from ROM q port

## Operation
- Issue select, each cycle:
  - blank=1: rom_addr=pix_addr; aux_gnt=0.
  - blank=0 and any aux_req: rom_addr=aux_addr[g]; aux_gnt[g]=1, where g is the round-robin winner.
  - Otherwise rom_addr=IDLE_ADDR.
- Round-robin: the search starts at last_gnt+1 (mod N_AUX). last_gnt updates only on a grant. Reset value is N_AUX-1, so aux 0 wins first.
- Requester handshake:
  - On the clock edge ending a cycle with aux_gnt[i]=1, the request is consumed.
  - The requester then drops aux_req or presents its next address; back-to-back grants to one requester are allowed if it is the only one requesting.
  - Deasserting aux_req without a grant withdraws the request; no side effects.
- Tag pipeline: ROM_LAT stages of {kind, id}, where kind ∈ {NONE, PIX, AUX}.
  - Stage 0 is loaded with the kind of the issued read.
  - The output stage drives the returns:
    - AUX: aux_valid[id]=1 and aux_q=rom_q.
    - PIX: pix_q=rom_q.
    - NONE: pix_q=BLANK_PAL.
- Reads issued in the last blanking cycle return during active video; their aux_valid is still delivered. There is no collision, because exactly one read is issued per cycle.
- Simultaneous requests: exactly one grant per cycle; the others wait. A requester waits at most N_AUX-1 granted cycles of blanking before its own grant.
- A transition of blank takes effect in the same cycle; an active aux_req is simply not granted while blank=1.

## Timing
- Pixel path: rom_addr follows pix_addr combinationally; pix_q is valid ROM_LAT clocks after issue, the same as a direct ROM connection.
- Aux path: aux_gnt is combinational from aux_req, blank and last_gnt. aux_valid[i] fires exactly ROM_LAT clocks after the aux_gnt[i] cycle.
- Reset (async assert, sync deassert by the system):
  - Tag pipeline is set to NONE and last_gnt to N_AUX-1.
  - Outputs: aux_valid=0 and pix_q=BLANK_PAL. aux_gnt follows blank and aux_req combinationally; it is 0 whenever blank=1 or aux_req=0.
  - In-flight reads are dropped with no aux_valid. aux_q is don't-care while aux_valid=0.
- Reset mid-read: no valid is emitted for reads issued before the reset edge.

## Structure
- Package sprite_rom_pkg:
  - ADDR_W, DATA_W, IDLE_ADDR and BLANK_PAL constants.
  - enum rd_kind_t {NONE, PIX, AUX}.
  - struct rd_tag_t {rd_kind_t kind; logic [1:0] id;}.
- Sub-module rr_arbiter:
  - Interface: N-way request vector in, one-hot grant out, enable input (= ~blank), registered last_gnt pointer updated on grant.
  - The top level holds the issue mux, the tag shift register and the return demux.

## Test plan
- Pixel passthrough: blank=1, pix_addr=100,101,102 on consecutive clocks, ROM_LAT=1 → rom_addr matches each cycle; pix_q = ROM[100],ROM[101],ROM[102] one clock later; aux_gnt stays 0 with aux_req=2'b11.
- Single aux read: blank=0, aux_req=2'b01, aux_addr[0]=1705 → aux_gnt=2'b01 that cycle; next clock aux_valid=2'b01 and aux_q=ROM[1705]; pix_q=BLANK_PAL.
- Fairness: blank=0 for 6 cycles, both requesters held high → grants alternate 01,10,01,10,01,10 starting with aux 0 after reset.
- Blank boundary: aux 1 granted in the last blank cycle, then blank=1 with pix_addr=200 → aux_valid=2'b10 in the first active cycle; pix_q=ROM[200] in the following cycle; no dropped or duplicated return.
- Idle: blank=0, aux_req=0 → rom_addr=1706 and aux_valid=0 on every cycle.
- Reset mid-operation: pulse Reset_n low for 1 clock right after an aux grant (ROM_LAT=2) → no aux_valid ever appears for that read; last_gnt is restored, so aux 0 wins next.
